// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: requester command codes and FSM states.
package counter_seq_pkg;

   typedef enum logic [1:0] {
      CMD_CLEAR = 2'b00,
      CMD_INC   = 2'b01,
      CMD_DEC   = 2'b10,
      CMD_LOAD  = 2'b11
   } cmd_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

endpackage

// File: rtl/counter_seq_prescaler.sv
// Free-running prescaler producing a non-accumulating autocount tick request
// (tick_pending) and a sticky overflow flag for ticks lost while one was pending.
module counter_seq_prescaler #(
   parameter int unsigned         DIV_W      = 24,
   parameter logic [DIV_W-1:0]    DIV_RELOAD = 24'h400000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic auto_en,
   input  logic tick_clr,
   output logic tick_pending,
   output logic tick_ovf
);

   logic [DIV_W-1:0] div_q;
   logic             pend_q;
   logic             ovf_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q  <= DIV_RELOAD;
         pend_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (div_q == '0) begin
            div_q <= DIV_RELOAD;
         end else begin
            div_q <= div_q - DIV_W'(1);
         end

         if (!auto_en) begin
            pend_q <= 1'b0;
         end else if (div_q == '0) begin
            // A tick landing on the cycle its predecessor is consumed is not lost.
            pend_q <= 1'b1;
            if (pend_q && !tick_clr) begin
               ovf_q <= 1'b1;
            end
         end else if (tick_clr) begin
            pend_q <= 1'b0;
         end
      end
   end

   assign tick_pending = pend_q;
   assign tick_ovf     = ovf_q;

endmodule

// File: rtl/counter_seq_arbiter.sv
// Round-robin sequencer sharing one counter between N_REQ requesters and an autocount tick.
// Define COUNTER_SEQ_SATURATE_EN to saturate INC/DEC at the range limits instead of wrapping.
module counter_seq_arbiter #(
   parameter int unsigned      N_REQ      = 3,
   parameter int unsigned      WIDTH      = 8,
   parameter int unsigned      DIV_W      = 24,
   parameter logic [DIV_W-1:0] DIV_RELOAD = 24'h400000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [2*N_REQ-1:0]     req_cmd,
   input  logic [WIDTH*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]       gnt,
   input  logic                   auto_en,
   input  logic                   hold,
   output logic [WIDTH-1:0]       count,
   output logic                   evt_zero,
   output logic                   evt_max,
   output logic                   evt_wrap,
   output logic                   tick_ovf
);

   import counter_seq_pkg::*;

   localparam int unsigned      IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [WIDTH-1:0] MAX   = '1;

   state_e           state_q;
   cmd_e             cmd_q;
   logic [WIDTH-1:0] data_q;
   logic [IDX_W-1:0] rr_q;
   logic [IDX_W-1:0] win_q;
   logic             from_tick_q;
   logic [N_REQ-1:0] gnt_q;
   logic [WIDTH-1:0] count_q;
   logic             evt_zero_q, evt_max_q, evt_wrap_q;

   logic             tick_pending;
   logic             tick_clr;
   logic             req_any;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   cmd_e             win_cmd;
   logic [WIDTH-1:0] win_data;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      req_any = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = IDX_W'((32'(rr_q) + i) % N_REQ);
         if (!req_any && req[cand]) begin
            req_any = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign win_cmd  = cmd_e'(req_cmd[2*int'(win_idx) +: 2]);
   assign win_data = req_data[WIDTH*int'(win_idx) +: WIDTH];
   assign tick_clr = (state_q == ST_IDLE) && !hold && !req_any && tick_pending;

   logic [WIDTH-1:0] cnt_nxt;
   logic             wrap_nxt;
   logic             noop_nxt;

   always_comb begin
      cnt_nxt  = count_q;
      wrap_nxt = 1'b0;
      noop_nxt = 1'b0;
      unique case (cmd_q)
         CMD_CLEAR: cnt_nxt = '0;
         CMD_INC: begin
            if (count_q == MAX) begin
`ifdef COUNTER_SEQ_SATURATE_EN
               noop_nxt = 1'b1;
`else
               cnt_nxt  = '0;
               wrap_nxt = 1'b1;
`endif
            end else begin
               cnt_nxt = count_q + WIDTH'(1);
            end
         end
         CMD_DEC: begin
            if (count_q == '0) begin
`ifdef COUNTER_SEQ_SATURATE_EN
               noop_nxt = 1'b1;
`else
               cnt_nxt  = MAX;
               wrap_nxt = 1'b1;
`endif
            end else begin
               cnt_nxt = count_q - WIDTH'(1);
            end
         end
         CMD_LOAD: cnt_nxt = data_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cmd_q       <= CMD_CLEAR;
         data_q      <= '0;
         rr_q        <= IDX_W'(N_REQ - 1);
         win_q       <= '0;
         from_tick_q <= 1'b0;
         gnt_q       <= '0;
         count_q     <= '0;
         evt_zero_q  <= 1'b0;
         evt_max_q   <= 1'b0;
         evt_wrap_q  <= 1'b0;
      end else begin
         gnt_q      <= '0;
         evt_zero_q <= 1'b0;
         evt_max_q  <= 1'b0;
         evt_wrap_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (!hold && req_any) begin
                  state_q     <= ST_EXEC;
                  gnt_q       <= N_REQ'(1) << win_idx;
                  cmd_q       <= win_cmd;
                  data_q      <= win_data;
                  win_q       <= win_idx;
                  from_tick_q <= 1'b0;
               end else if (tick_clr) begin
                  state_q     <= ST_EXEC;
                  cmd_q       <= CMD_INC;
                  from_tick_q <= 1'b1;
               end
            end
            ST_EXEC: begin
               count_q    <= cnt_nxt;
               evt_zero_q <= (cnt_nxt == '0) && !noop_nxt;
               evt_max_q  <= (cnt_nxt == MAX) && !noop_nxt;
               evt_wrap_q <= wrap_nxt;
               if (!from_tick_q) begin
                  rr_q <= win_q;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   counter_seq_prescaler #(
      .DIV_W      (DIV_W),
      .DIV_RELOAD (DIV_RELOAD)
   ) u_prescaler (
      .clk          (clk),
      .reset_n      (reset_n),
      .auto_en      (auto_en),
      .tick_clr     (tick_clr),
      .tick_pending (tick_pending),
      .tick_ovf     (tick_ovf)
   );

   assign gnt      = gnt_q;
   assign count    = count_q;
   assign evt_zero = evt_zero_q;
   assign evt_max  = evt_max_q;
   assign evt_wrap = evt_wrap_q;

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Directed bench for counter_seq_arbiter: a command vector table plus hand-timed
// sequences for round-robin order, hold, reset during EXEC and tick starvation.
module tb_counter_seq_arbiter;

   logic        clk;
   logic        reset_n;
   logic [2:0]  req;
   logic [5:0]  req_cmd;
   logic [23:0] req_data;
   logic [2:0]  gnt;
   logic        auto_en;
   logic        hold;
   logic [7:0]  count;
   logic        evt_zero, evt_max, evt_wrap;
   logic        tick_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   counter_seq_arbiter #(
      .N_REQ      (3),
      .WIDTH      (8),
      .DIV_W      (24),
      .DIV_RELOAD (24'd3)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .req_cmd  (req_cmd),
      .req_data (req_data),
      .gnt      (gnt),
      .auto_en  (auto_en),
      .hold     (hold),
      .count    (count),
      .evt_zero (evt_zero),
      .evt_max  (evt_max),
      .evt_wrap (evt_wrap),
      .tick_ovf (tick_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [1:0] cmd;
      logic [7:0] data;
      logic [7:0] exp_count;
      logic [2:0] exp_evt; // {zero, max, wrap}
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(int idx, logic [1:0] cmd, logic [7:0] data,
                               logic [7:0] exp_count, logic [2:0] exp_evt);
      vec_t v;
      v.idx = idx; v.cmd = cmd; v.data = data;
      v.exp_count = exp_count; v.exp_evt = exp_evt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset_n = 1'b0; req = '0; req_cmd = '0; req_data = '0; hold = 1'b0; auto_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Single request from an idle DUT: gnt one cycle later, result one cycle after that.
   task automatic do_cmd(input string name, input int idx, input logic [1:0] cmd,
                         input logic [7:0] data, input logic [7:0] exp_count,
                         input logic [2:0] exp_evt);
      logic [2:0] exp_gnt;
      exp_gnt = 3'b001 << idx;
      req_cmd[2*idx +: 2]  = cmd;
      req_data[8*idx +: 8] = data;
      req[idx]             = 1'b1;
      tick_sample();
      check({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
      req[idx] = 1'b0;
      tick_sample();
      check({name, " count"}, 32'(count), 32'(exp_count));
      check({name, " evt"}, 32'({evt_zero, evt_max, evt_wrap}), 32'(exp_evt));
      check({name, " gnt low"}, 32'(gnt), 32'd0);
   endtask

   initial begin
      vecs[0]  = mk(0, 2'b01, 8'h00, 8'h01, 3'b000);
      vecs[1]  = mk(1, 2'b11, 8'hFE, 8'hFE, 3'b000);
      vecs[2]  = mk(2, 2'b01, 8'h00, 8'hFF, 3'b010);
`ifdef COUNTER_SEQ_SATURATE_EN
      vecs[3]  = mk(0, 2'b01, 8'h00, 8'hFF, 3'b000);
      vecs[4]  = mk(1, 2'b10, 8'h00, 8'hFE, 3'b000);
      vecs[5]  = mk(2, 2'b11, 8'h00, 8'h00, 3'b100);
      vecs[6]  = mk(0, 2'b10, 8'h00, 8'h00, 3'b000);
`else
      vecs[3]  = mk(0, 2'b01, 8'h00, 8'h00, 3'b101);
      vecs[4]  = mk(1, 2'b10, 8'h00, 8'hFF, 3'b011);
      vecs[5]  = mk(2, 2'b11, 8'h00, 8'h00, 3'b100);
      vecs[6]  = mk(0, 2'b10, 8'h00, 8'hFF, 3'b011);
`endif
      vecs[7]  = mk(1, 2'b00, 8'h00, 8'h00, 3'b100);
      vecs[8]  = mk(2, 2'b00, 8'h00, 8'h00, 3'b100);
      vecs[9]  = mk(0, 2'b11, 8'h80, 8'h80, 3'b000);
      vecs[10] = mk(1, 2'b10, 8'h00, 8'h7F, 3'b000);
      vecs[11] = mk(2, 2'b11, 8'hFF, 8'hFF, 3'b010);
      vecs[12] = mk(0, 2'b11, 8'hFF, 8'hFF, 3'b010);

      reset_dut();
      check("reset count", 32'(count), 32'd0);
      check("reset gnt", 32'(gnt), 32'd0);
      check("reset evt", 32'({evt_zero, evt_max, evt_wrap}), 32'd0);
      check("reset tick_ovf", 32'(tick_ovf), 32'd0);

      for (int i = 0; i < 13; i++) begin
         do_cmd($sformatf("vec%0d", i), vecs[i].idx, vecs[i].cmd, vecs[i].data,
                vecs[i].exp_count, vecs[i].exp_evt);
      end

      // Round robin: all three INC, each dropped for one cycle after its grant.
      reset_dut();
      req_cmd = 6'b01_01_01;
      req     = 3'b111;
      for (int k = 0; k < 6; k++) begin
         tick_sample();
         check($sformatf("rr gnt%0d", k), 32'(gnt), 32'(3'b001 << (k % 3)));
         req[k % 3] = 1'b0;
         tick_sample();
         check($sformatf("rr count%0d", k), 32'(count), 32'(k + 1));
         req = 3'b111;
      end
      req = '0;
      tick_sample();

      // Hold blocks arbitration; release grants the pending CLEAR.
      do_cmd("hold preload", 0, 2'b11, 8'h33, 8'h33, 3'b000);
      hold         = 1'b1;
      req_cmd[5:4] = 2'b00;
      req[2]       = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick_sample();
         check($sformatf("hold gnt%0d", k), 32'(gnt), 32'd0);
         check($sformatf("hold count%0d", k), 32'(count), 32'h33);
      end
      hold = 1'b0;
      tick_sample();
      check("hold release gnt", 32'(gnt), 32'b100);
      req[2] = 1'b0;
      tick_sample();
      check("hold release count", 32'(count), 32'd0);
      check("hold release evt", 32'({evt_zero, evt_max, evt_wrap}), 32'b100);

      // Reset asserted while a LOAD 55 is in EXEC.
      do_cmd("rst preload", 1, 2'b11, 8'h11, 8'h11, 3'b000);
      req_cmd[1:0]  = 2'b11;
      req_data[7:0] = 8'h55;
      req[0]        = 1'b1;
      tick_sample();
      check("rst exec gnt", 32'(gnt), 32'b001);
      reset_n = 1'b0;
      req     = '0;
      tick_sample();
      check("rst count", 32'(count), 32'd0);
      check("rst gnt", 32'(gnt), 32'd0);
      check("rst evt", 32'({evt_zero, evt_max, evt_wrap}), 32'd0);
      reset_n = 1'b1;
      tick_sample();
      check("rst after count", 32'(count), 32'd0);
      check("rst after evt", 32'({evt_zero, evt_max, evt_wrap}), 32'd0);

      // Tick starvation: req[1] INC held; ticks at edges 4 and 8 after reset release.
      reset_dut();
      auto_en      = 1'b1;
      req_cmd[3:2] = 2'b01;
      req          = 3'b010;
      for (int e = 1; e <= 8; e++) begin
         tick_sample();
         if (e % 2 == 0) check($sformatf("starve count e%0d", e), 32'(count), 32'(e / 2));
         if (e == 6) check("starve ovf early", 32'(tick_ovf), 32'd0);
         if (e == 8) check("starve ovf", 32'(tick_ovf), 32'd1);
      end
      req = '0;
      tick_sample();
      check("tick exec gnt", 32'(gnt), 32'd0);
      tick_sample();
      check("tick count", 32'(count), 32'd5);
      check("tick evt", 32'({evt_zero, evt_max, evt_wrap}), 32'd0);
      tick_sample();
      check("tick single", 32'(count), 32'd5);
      auto_en = 1'b0;
      repeat (2) tick_sample();
      check("tick off count", 32'(count), 32'd5);
      check("tick_ovf sticky", 32'(tick_ovf), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
